// File: rtl/control_unit.sv
// ID-stage main decoder for the RV32I pipeline: combinational control decode
// plus a sticky flag that remembers any unsupported encoding since reset.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic       branch,
  output logic       jump,
  output logic [1:0] alu_op,
  output logic [1:0] imm_sel,
  output logic [1:0] mem_width,
  output logic       auipc_sel,
  output logic       illegal,
  output logic       illegal_seen
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic [1:0] imm_sel;
    logic [1:0] mem_width;
    logic       auipc_sel;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl;
  logic  legal;

  always_comb begin
    // NOTE: every variable written here is defaulted first, so no path can infer a latch.
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OP_R: begin
        legal = (funct7 == F7_BASE) ||
                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      OP_I_ALU: begin
        // Only shifts carry funct7; SRAI is the single alternate encoding.
        case (funct3)
          3'b001:  legal = (funct7 == F7_BASE);
          3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b1;
        endcase
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b10;
      end
      OP_LOAD: begin
        legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_width  = funct3[1:0];
      end
      OP_STORE: begin
        legal = (funct3 < 3'b011);
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_sel   = 2'b01;
        dec.mem_width = funct3[1:0];
      end
      OP_BRANCH: begin
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec.branch  = 1'b1;
        dec.alu_op  = 2'b01;
        dec.imm_sel = 2'b10;
      end
      OP_JAL: begin
        legal = 1'b1;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.imm_sel   = 2'b11;
      end
      OP_JALR: begin
        legal = (funct3 == 3'b000);
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LUI: begin
        legal = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b11;
        dec.imm_sel   = 2'b11;
      end
      OP_AUIPC: begin
        legal = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_sel   = 2'b11;
        dec.auipc_sel = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default:             legal = 1'b0;
    endcase
  end

  // Unsupported encodings become a bubble rather than a partial decode.
  assign ctrl    = legal ? dec : '0;
  assign illegal = ~legal;

  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign alu_src    = ctrl.alu_src;
  assign branch     = ctrl.branch;
  assign jump       = ctrl.jump;
  assign alu_op     = ctrl.alu_op;
  assign imm_sel    = ctrl.imm_sel;
  assign mem_width  = ctrl.mem_width;
  assign auipc_sel  = ctrl.auipc_sel;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) illegal_seen <= 1'b0;
    else     illegal_seen <= illegal_seen | illegal;
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed RV32I encodings, the sticky-flag sequence,
// then random encodings checked against a table-driven reference decoder.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       reg_write, mem_to_reg, mem_read, mem_write, alu_src, branch, jump;
  logic [1:0] alu_op, imm_sel, mem_width;
  logic       auipc_sel, illegal, illegal_seen;

  int errors = 0;
  int checks = 0;
  logic seen_model;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src(alu_src), .branch(branch), .jump(jump),
    .alu_op(alu_op), .imm_sel(imm_sel), .mem_width(mem_width),
    .auipc_sel(auipc_sel), .illegal(illegal), .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  // {reg_write,mem_to_reg,mem_read,mem_write,alu_src,branch,jump,alu_op,imm_sel,mem_width,auipc_sel,illegal}
  logic [14:0] dut_vec;
  assign dut_vec = {reg_write, mem_to_reg, mem_read, mem_write, alu_src, branch, jump,
                    alu_op, imm_sel, mem_width, auipc_sel, illegal};

  // Reference: one control row per instruction class, then an independent legality rule.
  function automatic logic [14:0] ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7);
    logic [14:0] row;
    logic ok;
    row = '0;
    ok  = 1'b0;
    case (op)
      7'b0110011: begin row = 15'b1000000_10_00_00_0_0;
                        ok = (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}); end
      7'b0010011: begin row = 15'b1000100_10_00_00_0_0;
                        ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                             (f3 == 3'd5) ? (f7 inside {7'h00, 7'h20}) : 1'b1; end
      7'b0000011: begin row = {11'b1110100_00_00, f3[1:0], 2'b00};
                        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
      7'b0100011: begin row = {11'b0001100_00_01, f3[1:0], 2'b00};
                        ok = f3 inside {3'd0, 3'd1, 3'd2}; end
      7'b1100011: begin row = 15'b0000010_01_10_00_0_0; ok = !(f3 inside {3'd2, 3'd3}); end
      7'b1101111: begin row = 15'b1000001_00_11_00_0_0; ok = 1'b1; end
      7'b1100111: begin row = 15'b1000101_00_00_00_0_0; ok = (f3 == 3'd0); end
      7'b0110111: begin row = 15'b1000100_11_11_00_0_0; ok = 1'b1; end
      7'b0010111: begin row = 15'b1000100_00_11_00_1_0; ok = 1'b1; end
      7'b0001111, 7'b1110011: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok ? row : 15'b1;
  endfunction

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
    @(negedge clk);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    #1;
    check(tag, dut_vec, ref_decode(op, f3, f7));
  endtask

  task automatic tick(input string tag, input logic r);
    logic [14:0] cur;
    cur = ref_decode(opcode, funct3, funct7);
    rst = r;
    @(posedge clk);
    seen_model = r ? 1'b0 : (seen_model | cur[0]);
    #1;
    check(tag, {14'b0, illegal_seen}, {14'b0, seen_model});
    rst = 1'b0;
  endtask

  logic [6:0] legal_ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111, 7'b0001111, 7'b1110011};

  initial begin
    rst = 1'b1;
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h00;
    seen_model = 1'b0;
    tick("reset_seen", 1'b1);

    drive("add", 7'b0110011, 3'b000, 7'h00);
    check("add_alu_op", {13'b0, alu_op}, 15'd2);
    drive("sub", 7'b0110011, 3'b000, 7'h20);
    drive("sra", 7'b0110011, 3'b101, 7'h20);
    drive("addi", 7'b0010011, 3'b000, 7'h55);
    drive("srai", 7'b0010011, 3'b101, 7'h20);
    drive("lui", 7'b0110111, 3'b011, 7'h11);
    check("lui_imm_sel", {13'b0, imm_sel}, 15'd3);
    drive("lw", 7'b0000011, 3'b010, 7'h00);
    check("lw_width", {13'b0, mem_width}, 15'd2);
    drive("lbu", 7'b0000011, 3'b100, 7'h00);
    drive("lhu", 7'b0000011, 3'b101, 7'h00);
    drive("sw", 7'b0100011, 3'b010, 7'h00);
    drive("beq", 7'b1100011, 3'b000, 7'h00);
    drive("bgeu", 7'b1100011, 3'b111, 7'h00);
    drive("jal", 7'b1101111, 3'b101, 7'h7f);
    drive("jalr", 7'b1100111, 3'b000, 7'h00);
    drive("auipc", 7'b0010111, 3'b000, 7'h00);
    check("auipc_sel", {14'b0, auipc_sel}, 15'd1);
    drive("fence", 7'b0001111, 3'b000, 7'h00);
    drive("ecall", 7'b1110011, 3'b000, 7'h00);
    tick("seen_legal", 1'b0);

    drive("ld_bad", 7'b0000011, 3'b011, 7'h00);
    drive("lwu_bad", 7'b0000011, 3'b110, 7'h00);
    drive("sd_bad", 7'b0100011, 3'b011, 7'h00);
    drive("br_bad", 7'b1100011, 3'b010, 7'h00);
    drive("jalr_bad", 7'b1100111, 3'b001, 7'h00);
    drive("r_f7_bad", 7'b0110011, 3'b000, 7'h01);
    drive("r_alt_bad", 7'b0110011, 3'b001, 7'h20);
    drive("slli_bad", 7'b0010011, 3'b001, 7'h20);
    drive("srli_bad", 7'b0010011, 3'b101, 7'h10);

    // Sticky flag sequence.
    drive("ctl_add", 7'b0110011, 3'b000, 7'h00);
    tick("seq_reset", 1'b1);
    drive("op_7f", 7'b1111111, 3'b000, 7'h00);
    check("op_7f_illegal", {14'b0, illegal}, 15'd1);
    tick("seq_set", 1'b0);
    drive("seq_add", 7'b0110011, 3'b000, 7'h00);
    tick("seq_hold", 1'b0);
    tick("seq_clear", 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [6:0] op, f7;
      logic [2:0] f3;
      int pick;
      pick = int'($urandom_range(0, 13));
      op   = (pick < 11) ? legal_ops[pick] : 7'($urandom);
      f3   = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      drive("rand_ctrl", op, f3, f7);
      tick("rand_seen", ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
